// File: rtl/pp_pipeline_accel_dl_pkg.sv
// Shared types and helpers for the HLS deadlock report controller.
// Widths here bound the DETECT_CYCLES and TIMEOUT_CYCLES parameters of the top.
package pp_pipeline_accel_dl_pkg;

  localparam int MAX_PROC_NUM = 32;
  localparam int MAX_IDX_W    = 5;
  localparam int FILT_CNT_W   = 8;
  localparam int TIMER_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILTER = 3'd1,
    ST_ORIGIN = 3'd2,
    ST_WALK   = 3'd3,
    ST_DONE   = 3'd4
  } dl_state_e;

  // Scans from the top down so the last hit written is the lowest set index.
  function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_PROC_NUM-1:0] vec);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = MAX_PROC_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = MAX_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_dl_prio_enc.sv
// Lowest-set-bit priority encoder with valid flag, used to elect the origin process.
module pp_pipeline_accel_dl_prio_enc
  import pp_pipeline_accel_dl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  logic [MAX_PROC_NUM-1:0] vec_ext_s;

  assign vec_ext_s = MAX_PROC_NUM'(vec);
  assign idx       = $clog2(N)'(lowest_set_idx(vec_ext_s));
  assign valid     = |vec;

endmodule

// File: rtl/pp_pipeline_accel_hls_deadlock_report_ctrl.sv
// Sequencer for per-process HLS deadlock detect units: elects one origin, walks one token, latches the chain.
// Optional hop counter enabled by defining PP_PIPELINE_ACCEL_DL_HOP_COUNT_EN.
module pp_pipeline_accel_hls_deadlock_report_ctrl
  import pp_pipeline_accel_dl_pkg::*;
#(
  parameter int PROC_NUM       = 4,
  parameter int DETECT_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [PROC_NUM-1:0]                   dl_in_vec,
  input  logic                                  report_ack,
  output logic                                  dl_detect_out,
  output logic [PROC_NUM-1:0]                   origin,
  output logic                                  token_clear,
  output logic                                  deadlock_detected,
  output logic [PROC_NUM-1:0]                   deadlock_origin,
  output logic [PROC_NUM-1:0]                   deadlock_chain,
  output logic                                  deadlock_timeout,
  output logic                                  report_valid,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]   hop_count
);

  localparam int IDX_W = $clog2(PROC_NUM);
  localparam int HOP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_CNT_W-1:0] DET_TARGET = FILT_CNT_W'(DETECT_CYCLES);
  localparam logic [TIMER_W-1:0]    TMO_LAST   = TIMER_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [PROC_NUM-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(PROC_NUM-1){1'b0}}, 1'b1} << i;
  endfunction

  dl_state_e               state_q, state_d;
  logic [IDX_W-1:0]        cand_q, cand_d;
  logic [FILT_CNT_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [PROC_NUM-1:0]     dl_origin_q, dl_origin_d;
  logic [PROC_NUM-1:0]     chain_q, chain_d;
  logic                    tmo_flag_q, tmo_flag_d;
  logic [PROC_NUM-1:0]     origin_q, origin_d;
  logic                    dl_detect_q, dl_detect_d;
  logic                    detected_q, detected_d;
  logic                    report_valid_q, report_valid_d;

  logic [IDX_W-1:0]        enc_idx_s;
  logic                    enc_valid_s;
  logic                    hit_s;
  logic                    tmo_s;
  logic                    token_clear_s;

  pp_pipeline_accel_dl_prio_enc #(.N(PROC_NUM)) u_prio_enc (
    .vec   (dl_in_vec),
    .idx   (enc_idx_s),
    .valid (enc_valid_s)
  );

  // Next-state and report-register logic; hit takes priority over timeout at closure.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    filt_cnt_d    = filt_cnt_q;
    timer_d       = timer_q;
    dl_origin_d   = dl_origin_q;
    chain_d       = chain_q;
    tmo_flag_d    = tmo_flag_q;
    hit_s         = dl_in_vec[cand_q];
    tmo_s         = (timer_q == TMO_LAST);
    token_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid_s) begin
          cand_d     = enc_idx_s;
          filt_cnt_d = FILT_CNT_W'(1);
          state_d    = (DETECT_CYCLES == 1) ? ST_ORIGIN : ST_FILTER;
        end else begin
          filt_cnt_d = {FILT_CNT_W{1'b0}};
        end
      end
      ST_FILTER: begin
        if (hit_s) begin
          filt_cnt_d = filt_cnt_q + FILT_CNT_W'(1);
          if (filt_cnt_d == DET_TARGET) begin
            state_d = ST_ORIGIN;
          end else begin
            state_d = ST_FILTER;
          end
        end else begin
          filt_cnt_d = {FILT_CNT_W{1'b0}};
          state_d    = ST_IDLE;
        end
      end
      ST_ORIGIN: begin
        dl_origin_d = onehot(cand_q);
        chain_d     = onehot(cand_q);
        timer_d     = {TIMER_W{1'b0}};
        filt_cnt_d  = {FILT_CNT_W{1'b0}};
        state_d     = ST_WALK;
      end
      ST_WALK: begin
        chain_d       = chain_q | dl_in_vec;
        timer_d       = timer_q + TIMER_W'(1);
        token_clear_s = hit_s | tmo_s;
        if (hit_s || tmo_s) begin
          tmo_flag_d = tmo_s & ~hit_s;
          state_d    = ST_DONE;
        end else begin
          state_d = ST_WALK;
        end
      end
      ST_DONE: begin
        if (report_ack) begin
          dl_origin_d = {PROC_NUM{1'b0}};
          chain_d     = {PROC_NUM{1'b0}};
          tmo_flag_d  = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    origin_d       = (state_d == ST_ORIGIN) ? onehot(cand_d) : {PROC_NUM{1'b0}};
    dl_detect_d    = (state_d == ST_ORIGIN) || (state_d == ST_WALK) || (state_d == ST_DONE);
    detected_d     = (state_d == ST_DONE);
    report_valid_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  // State and registered outputs; async reset drops the unit-facing strobes at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cand_q         <= {IDX_W{1'b0}};
      filt_cnt_q     <= {FILT_CNT_W{1'b0}};
      timer_q        <= {TIMER_W{1'b0}};
      dl_origin_q    <= {PROC_NUM{1'b0}};
      chain_q        <= {PROC_NUM{1'b0}};
      tmo_flag_q     <= 1'b0;
      origin_q       <= {PROC_NUM{1'b0}};
      dl_detect_q    <= 1'b0;
      detected_q     <= 1'b0;
      report_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      filt_cnt_q     <= filt_cnt_d;
      timer_q        <= timer_d;
      dl_origin_q    <= dl_origin_d;
      chain_q        <= chain_d;
      tmo_flag_q     <= tmo_flag_d;
      origin_q       <= origin_d;
      dl_detect_q    <= dl_detect_d;
      detected_q     <= detected_d;
      report_valid_q <= report_valid_d;
    end
  end

`ifdef PP_PIPELINE_ACCEL_DL_HOP_COUNT_EN
  localparam logic [HOP_W-1:0] HOP_SAT = HOP_W'(TIMEOUT_CYCLES);
  logic [HOP_W-1:0] hop_q, hop_d;

  // WALK length including the closing cycle, saturating at the timeout.
  always_comb begin
    hop_d = hop_q;
    case (state_q)
      ST_ORIGIN: hop_d = {HOP_W{1'b0}};
      ST_WALK: begin
        if (hop_q != HOP_SAT) begin
          hop_d = hop_q + HOP_W'(1);
        end else begin
          hop_d = hop_q;
        end
      end
      ST_DONE: begin
        if (report_ack) begin
          hop_d = {HOP_W{1'b0}};
        end else begin
          hop_d = hop_q;
        end
      end
      default: hop_d = hop_q;
    endcase
  end

  // Hop counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hop_q <= {HOP_W{1'b0}};
    end else begin
      hop_q <= hop_d;
    end
  end

  assign hop_count = hop_q;
`else
  assign hop_count = {HOP_W{1'b0}};
`endif

  assign dl_detect_out     = dl_detect_q;
  assign origin            = origin_q;
  assign token_clear       = token_clear_s & (state_q == ST_WALK);
  assign deadlock_detected = detected_q;
  assign deadlock_origin   = dl_origin_q;
  assign deadlock_chain    = chain_q;
  assign deadlock_timeout  = tmo_flag_q;
  assign report_valid      = report_valid_q;

endmodule

// File: tb/tb_pp_pipeline_accel_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller (PROC_NUM=4, DETECT_CYCLES=2, TIMEOUT_CYCLES=8).
module tb_pp_pipeline_accel_hls_deadlock_report_ctrl;

  localparam int PN  = 4;
  localparam int TMO = 8;
  localparam int HW  = $clog2(TMO + 1);

  logic          clock;
  logic          rst_n;
  logic [PN-1:0] dl_in_vec;
  logic          report_ack;
  logic          dl_detect_out;
  logic [PN-1:0] origin;
  logic          token_clear;
  logic          deadlock_detected;
  logic [PN-1:0] deadlock_origin;
  logic [PN-1:0] deadlock_chain;
  logic          deadlock_timeout;
  logic          report_valid;
  logic [HW-1:0] hop_count;

  int n_cmp;
  int n_bad;

  pp_pipeline_accel_hls_deadlock_report_ctrl #(
    .PROC_NUM       (PN),
    .DETECT_CYCLES  (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock             (clock),
    .reset             (rst_n),
    .dl_in_vec         (dl_in_vec),
    .report_ack        (report_ack),
    .dl_detect_out     (dl_detect_out),
    .origin            (origin),
    .token_clear       (token_clear),
    .deadlock_detected (deadlock_detected),
    .deadlock_origin   (deadlock_origin),
    .deadlock_chain    (deadlock_chain),
    .deadlock_timeout  (deadlock_timeout),
    .report_valid      (report_valid),
    .hop_count         (hop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int exp_hop(input int n);
`ifdef PP_PIPELINE_ACCEL_DL_HOP_COUNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".dl_detect_out"}, 32'(dl_detect_out), 32'h0);
    check({tag, ".origin"}, 32'(origin), 32'h0);
    check({tag, ".token_clear"}, 32'(token_clear), 32'h0);
    check({tag, ".detected"}, 32'(deadlock_detected), 32'h0);
    check({tag, ".dorigin"}, 32'(deadlock_origin), 32'h0);
    check({tag, ".chain"}, 32'(deadlock_chain), 32'h0);
    check({tag, ".timeout"}, 32'(deadlock_timeout), 32'h0);
    check({tag, ".report_valid"}, 32'(report_valid), 32'h0);
    check({tag, ".hop"}, 32'(hop_count), 32'h0);
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    dl_in_vec  = 4'b0000;
    report_ack = 1'b0;
    step(); step();
    mid();
    check_all_zero("in_reset");
    step();
    rst_n = 1'b1;
    mid();
    check_all_zero("after_reset");

    // Quiet ring: single-cycle blip enters FILTER and falls back to IDLE.
    step(); dl_in_vec = 4'b0100;
    mid();  check("quiet.detect0", 32'(dl_detect_out), 32'h0);
    step(); dl_in_vec = 4'b0000;
    mid();  check("quiet.detect1", 32'(dl_detect_out), 32'h0);
    step(); mid();
    check("quiet.origin", 32'(origin), 32'h0);
    check("quiet.detect2", 32'(dl_detect_out), 32'h0);
    step(); mid();
    check("quiet.detect3", 32'(dl_detect_out), 32'h0);

    // Two detects held 2 cycles: lowest index (1) elected.
    step(); dl_in_vec = 4'b0110;
    step(); mid();
    check("elect.filter_detect", 32'(dl_detect_out), 32'h0);
    step(); dl_in_vec = 4'b0000;
    mid();
    check("elect.origin", 32'(origin), 32'h2);
    check("elect.detect", 32'(dl_detect_out), 32'h1);
    check("elect.tc", 32'(token_clear), 32'h0);
    step(); dl_in_vec = 4'b0100;
    mid();
    check("walk1.origin", 32'(origin), 32'h0);
    check("walk1.dorigin", 32'(deadlock_origin), 32'h2);
    check("walk1.tc", 32'(token_clear), 32'h0);
    check("walk1.detect", 32'(dl_detect_out), 32'h1);
    step(); dl_in_vec = 4'b0000; report_ack = 1'b1;
    mid();
    check("walk2.tc", 32'(token_clear), 32'h0);
    step(); dl_in_vec = 4'b0010; report_ack = 1'b0;
    mid();
    check("walk3.tc", 32'(token_clear), 32'h1);
    check("walk3.ack_ignored", 32'(deadlock_detected), 32'h0);
    check("walk3.detect", 32'(dl_detect_out), 32'h1);
    step(); dl_in_vec = 4'b0000;
    mid();
    check("done.report_valid", 32'(report_valid), 32'h1);
    check("done.detected", 32'(deadlock_detected), 32'h1);
    check("done.chain", 32'(deadlock_chain), 32'h6);
    check("done.timeout", 32'(deadlock_timeout), 32'h0);
    check("done.hop", 32'(hop_count), 32'(exp_hop(3)));
    check("done.dorigin", 32'(deadlock_origin), 32'h2);
    check("done.detect", 32'(dl_detect_out), 32'h1);
    check("done.tc", 32'(token_clear), 32'h0);
    step(); mid();
    check("done2.report_valid", 32'(report_valid), 32'h0);
    check("done2.detected", 32'(deadlock_detected), 32'h1);
    step(); report_ack = 1'b1;
    step(); report_ack = 1'b0;
    mid();
    check_all_zero("ack1");

    // Timeout: origin 3 never returns, closure on 8th WALK cycle.
    step(); dl_in_vec = 4'b1000;
    step();
    step(); dl_in_vec = 4'b0000;
    for (int k = 1; k <= TMO; k++) begin
      step(); mid();
      if (k == TMO - 1) check("tmo.tc_early", 32'(token_clear), 32'h0);
      if (k == TMO)     check("tmo.tc_last", 32'(token_clear), 32'h1);
    end
    step(); mid();
    check("tmo.detected", 32'(deadlock_detected), 32'h1);
    check("tmo.timeout", 32'(deadlock_timeout), 32'h1);
    check("tmo.chain", 32'(deadlock_chain), 32'h8);
    check("tmo.dorigin", 32'(deadlock_origin), 32'h8);
    check("tmo.hop", 32'(hop_count), 32'(exp_hop(TMO)));
    step(); report_ack = 1'b1;
    step(); report_ack = 1'b0;
    mid();
    check_all_zero("ack2");

    // Hit and timeout in the same cycle: hit wins.
    step(); dl_in_vec = 4'b0001;
    step();
    step(); dl_in_vec = 4'b0000;
    for (int k = 1; k <= TMO; k++) begin
      step();
      dl_in_vec = (k == TMO) ? 4'b0001 : 4'b0000;
      mid();
      if (k == TMO) check("both.tc", 32'(token_clear), 32'h1);
    end
    step(); dl_in_vec = 4'b0000;
    mid();
    check("both.detected", 32'(deadlock_detected), 32'h1);
    check("both.timeout", 32'(deadlock_timeout), 32'h0);
    check("both.chain", 32'(deadlock_chain), 32'h1);
    check("both.hop", 32'(hop_count), 32'(exp_hop(TMO)));
    step(); report_ack = 1'b1;
    step(); report_ack = 1'b0;
    mid();
    check_all_zero("ack3");

    // Async reset mid-WALK while the origin bit is returning.
    step(); dl_in_vec = 4'b0010;
    step();
    step();
    step(); mid();
    check("rstwalk.tc_pre", 32'(token_clear), 32'h1);
    check("rstwalk.detect_pre", 32'(dl_detect_out), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwalk.tc", 32'(token_clear), 32'h0);
    check("rstwalk.detect", 32'(dl_detect_out), 32'h0);
    check("rstwalk.origin", 32'(origin), 32'h0);
    dl_in_vec = 4'b0000;
    step();
    step(); rst_n = 1'b1;
    mid();
    check_all_zero("rstwalk.after");

    // Async reset during ORIGIN drops the origin strobe.
    step(); dl_in_vec = 4'b0100;
    step();
    step(); mid();
    check("rstorg.origin_pre", 32'(origin), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rstorg.origin", 32'(origin), 32'h0);
    check("rstorg.detect", 32'(dl_detect_out), 32'h0);
    dl_in_vec = 4'b0000;
    step();
    step(); rst_n = 1'b1;
    mid();
    check_all_zero("rstorg.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
